rob_commit_wide: RTL

//  Reorder buffer with a retirement RAT that commits up to COMMIT_WIDTH instructions per cycle, in order.

---
 rtl/rob_commit_wide.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_commit_wide.sv
// rob_commit_wide: reorder buffer that retires up to COMMIT_WIDTH entries
// per cycle in order, keeps the retirement RAT and drives flush/redirect.
//
// Ports:
//   CLK, RESET (async, active-low), FREEZE (stall dispatch and commit)
//   disp_*   : one push per cycle at the tail; disp_robIdx_OUT is the index
//              the push gets, disp_ready_OUT is count < DEPTH
//   cmpl_*   : completion write-back by ROB index (fin/exc/redir/target)
//   retire_valid_OUT / free_valid_OUT / free_id_OUT : registered per-lane
//              retire and free-list pulses
//   retRat_OUT : retirement RAT, arch r at [r*PREG_W +: PREG_W]
//   flushEm_OUT / copyRetRat_OUT / setPC_OUT / targetPC_OUT : flush pulse
//   robHead_OUT, robCount_OUT : occupancy
//
// Build option: define COMMIT_STATS_EN to add the saturating counters
// stat_retired_OUT[31:0] and stat_flushes_OUT[15:0].

module rob_commit_wide #(
   parameter int          ROB_ADDRWIDTH = 4,
   parameter int          COMMIT_WIDTH  = 2,
   parameter int          AREG_W        = 5,
   parameter int          PREG_W        = 6,
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180
) (
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic                               FREEZE,
   input  logic                               disp_valid_IN,
   input  logic                               disp_destReqd_IN,
   input  logic [AREG_W-1:0]                  disp_archDest_IN,
   input  logic [PREG_W-1:0]                  disp_physDest_IN,
   output logic                               disp_ready_OUT,
   output logic [ROB_ADDRWIDTH-1:0]           disp_robIdx_OUT,
   input  logic                               cmpl_valid_IN,
   input  logic [ROB_ADDRWIDTH-1:0]           cmpl_idx_IN,
   input  logic                               cmpl_exc_IN,
   input  logic                               cmpl_redirect_IN,
   input  logic [31:0]                        cmpl_target_IN,
   output logic [COMMIT_WIDTH-1:0]            retire_valid_OUT,
   output logic [COMMIT_WIDTH-1:0]            free_valid_OUT,
   output logic [COMMIT_WIDTH*PREG_W-1:0]     free_id_OUT,
   output logic [(1<<AREG_W)*PREG_W-1:0]      retRat_OUT,
   output logic                               flushEm_OUT,
   output logic                               copyRetRat_OUT,
   output logic                               setPC_OUT,
   output logic [31:0]                        targetPC_OUT,
   output logic [ROB_ADDRWIDTH-1:0]           robHead_OUT,
   output logic [ROB_ADDRWIDTH:0]             robCount_OUT
`ifdef COMMIT_STATS_EN
   ,
   output logic [31:0]                        stat_retired_OUT,
   output logic [15:0]                        stat_flushes_OUT
`endif
);

   localparam int DEPTH    = 1 << ROB_ADDRWIDTH;
   localparam int NUM_AREG = 1 << AREG_W;
   localparam logic [ROB_ADDRWIDTH:0] FULL = (ROB_ADDRWIDTH+1)'(DEPTH);

   logic [ROB_ADDRWIDTH-1:0] head;
   logic [ROB_ADDRWIDTH-1:0] tail;
   logic [ROB_ADDRWIDTH:0]   count;

   logic [DEPTH-1:0]   fin;
   logic [DEPTH-1:0]   exc;
   logic [DEPTH-1:0]   redir;
   logic [DEPTH-1:0]   dest_reqd;
   logic [31:0]        target    [DEPTH];
   logic [AREG_W-1:0]  arch_dest [DEPTH];
   logic [PREG_W-1:0]  phys_dest [DEPTH];
   logic [PREG_W-1:0]  retrat    [NUM_AREG];

   logic                     push;
   logic                     cmpl_hit;
   logic [ROB_ADDRWIDTH-1:0] cmpl_off;
   logic [COMMIT_WIDTH-1:0]  ret;
   logic [COMMIT_WIDTH-1:0]  fv;
   logic [PREG_W-1:0]        fid     [COMMIT_WIDTH];
   logic [PREG_W-1:0]        rat_nxt [NUM_AREG];
   logic [ROB_ADDRWIDTH:0]   n_ret;
   logic                     trig_exc;
   logic                     trig_redir;
   logic                     trig;
   logic                     go;
   logic [31:0]              redir_tgt;
   logic [ROB_ADDRWIDTH-1:0] idx;

   assign disp_ready_OUT  = count < FULL;
   assign disp_robIdx_OUT = tail;
   assign robHead_OUT     = head;
   assign robCount_OUT    = count;

   assign push = disp_valid_IN & disp_ready_OUT & ~FREEZE & ~flushEm_OUT;

   // Offset from head decides whether the index is currently occupied.
   assign cmpl_off = cmpl_idx_IN - head;
   assign cmpl_hit = cmpl_valid_IN & ~flushEm_OUT
                   & ({1'b0, cmpl_off} < count);

   assign trig = trig_exc | trig_redir;

   always_comb begin
      retRat_OUT = '0;
      for (int r = 0; r < NUM_AREG; r++) begin
         retRat_OUT[r*PREG_W +: PREG_W] = retrat[r];
      end
   end

   // Walk the lanes from head. rat_nxt is updated lane by lane so a later
   // lane with the same archDest sees (and frees) the earlier lane's
   // mapping, and the last writer wins.
   always_comb begin
      ret        = '0;
      fv         = '0;
      trig_exc   = 1'b0;
      trig_redir = 1'b0;
      redir_tgt  = '0;
      go         = ~FREEZE;
      idx        = head;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         fid[k] = '0;
      end
      for (int r = 0; r < NUM_AREG; r++) begin
         rat_nxt[r] = retrat[r];
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         idx = head + ROB_ADDRWIDTH'(k);
         if (go && ((ROB_ADDRWIDTH+1)'(k) < count) && fin[idx]) begin
            if (exc[idx]) begin
               trig_exc = 1'b1;
               go       = 1'b0;
            end else begin
               ret[k] = 1'b1;
               if (dest_reqd[idx] && (arch_dest[idx] != '0)) begin
                  fv[k]  = 1'b1;
                  fid[k] = rat_nxt[arch_dest[idx]];
                  rat_nxt[arch_dest[idx]] = phys_dest[idx];
               end
               if (redir[idx]) begin
                  trig_redir = 1'b1;
                  redir_tgt  = target[idx];
                  go         = 1'b0;
               end
            end
         end else begin
            go = 1'b0;
         end
      end
   end

   always_comb begin
      n_ret = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         n_ret = n_ret + {{ROB_ADDRWIDTH{1'b0}}, ret[k]};
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         fin              <= '0;
         exc              <= '0;
         redir            <= '0;
         retire_valid_OUT <= '0;
         free_valid_OUT   <= '0;
         free_id_OUT      <= '0;
         flushEm_OUT      <= 1'b0;
         copyRetRat_OUT   <= 1'b0;
         setPC_OUT        <= 1'b0;
         targetPC_OUT     <= '0;
         for (int r = 0; r < NUM_AREG; r++) begin
            retrat[r] <= PREG_W'(r);
         end
      end else begin
         retire_valid_OUT <= ret;
         free_valid_OUT   <= fv;
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            free_id_OUT[k*PREG_W +: PREG_W] <= fid[k];
         end
         for (int r = 0; r < NUM_AREG; r++) begin
            retrat[r] <= rat_nxt[r];
         end
         flushEm_OUT    <= trig;
         copyRetRat_OUT <= trig;
         setPC_OUT      <= trig;
         if (trig) begin
            targetPC_OUT <= trig_exc ? EXC_VECTOR : redir_tgt;
         end
         if (push) begin
            fin[tail]   <= 1'b0;
            exc[tail]   <= 1'b0;
            redir[tail] <= 1'b0;
         end
         if (cmpl_hit) begin
            fin[cmpl_idx_IN]   <= 1'b1;
            exc[cmpl_idx_IN]   <= cmpl_exc_IN;
            redir[cmpl_idx_IN] <= cmpl_redirect_IN;
         end
         if (trig) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            head  <= head + n_ret[ROB_ADDRWIDTH-1:0];
            tail  <= tail + ROB_ADDRWIDTH'(push);
            count <= count + (ROB_ADDRWIDTH+1)'(push) - n_ret;
         end
      end
   end

   // Payload needs no reset: it is always written by the push or the
   // completion before commit can look at it.
   always_ff @(posedge CLK) begin
      if (push) begin
         dest_reqd[tail] <= disp_destReqd_IN;
         arch_dest[tail] <= disp_archDest_IN;
         phys_dest[tail] <= disp_physDest_IN;
      end
      if (cmpl_hit) begin
         target[cmpl_idx_IN] <= cmpl_target_IN;
      end
   end

`ifdef COMMIT_STATS_EN
   logic [2:0]  ret_pop;
   logic [32:0] ret_sum;

   always_comb begin
      ret_pop = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         ret_pop = ret_pop + {2'b00, retire_valid_OUT[k]};
      end
   end

   assign ret_sum = {1'b0, stat_retired_OUT} + {30'b0, ret_pop};

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stat_retired_OUT <= '0;
         stat_flushes_OUT <= '0;
      end else begin
         stat_retired_OUT <= ret_sum[32] ? '1 : ret_sum[31:0];
         if (flushEm_OUT && (stat_flushes_OUT != '1)) begin
            stat_flushes_OUT <= stat_flushes_OUT + 16'd1;
         end
      end
   end
`endif

endmodule
